// File: rtl/q_rotary_enc_mc.sv
// Multi-channel quadrature encoder counter: sync, glitch filter, Grey decode, 16-bit bus preload.
// Optional index (Z) capture is enabled by defining Q_ROTARY_ENC_MC_INDEX_EN.

module q_rotary_enc_mc_filter #(
   parameter int FLT_LEN = 4
) (
   input  logic clock,
   input  logic aclr,
   input  logic sclr,
   input  logic i_d,
   output logic o_q
);
   localparam int CW = (FLT_LEN > 1) ? $clog2(FLT_LEN) : 1;

   logic [CW-1:0] r_run;
   logic          r_q;

   // r_run counts consecutive samples that disagree with the current output
   always_ff @(posedge clock or posedge aclr) begin
      if (aclr) begin
         r_run <= '0;
         r_q   <= 1'b0;
      end else if (sclr) begin
         r_run <= '0;
         r_q   <= 1'b0;
      end else if (i_d == r_q) begin
         r_run <= '0;
      end else if (r_run == CW'(FLT_LEN - 1)) begin
         r_q   <= i_d;
         r_run <= '0;
      end else begin
         r_run <= r_run + CW'(1);
      end
   end

   assign o_q = r_q;
endmodule

module q_rotary_enc_mc #(
   parameter int CHANNELS = 2,
   parameter int WIDTH    = 32,
   parameter int FLT_LEN  = 4,
   localparam int ADDR_W  = (($clog2(CHANNELS) + $clog2(WIDTH / 16)) > 0) ?
                            ($clog2(CHANNELS) + $clog2(WIDTH / 16)) : 1
) (
   input  logic                      clock,
   input  logic                      aclr,
   input  logic                      sclr,
   input  logic                      ena,
   input  logic [CHANNELS-1:0]       dir,
   input  logic [CHANNELS-1:0]       A,
   input  logic [CHANNELS-1:0]       B,
   output logic [CHANNELS*WIDTH-1:0] counter,
   output logic [CHANNELS-1:0]       error,
   output logic [CHANNELS-1:0]       enc_changed,
`ifdef Q_ROTARY_ENC_MC_INDEX_EN
   input  logic [CHANNELS-1:0]       Z,
   output logic [CHANNELS*WIDTH-1:0] idx_pos,
   output logic [CHANNELS-1:0]       idx_valid,
   input  logic [CHANNELS-1:0]       idx_ack,
   input  logic [CHANNELS-1:0]       idx_zero,
`endif
   input  logic [ADDR_W-1:0]         addr,
   input  logic [1:0]                be,
   input  logic                      write,
   input  logic [15:0]               data
);
   localparam int NWORDS  = WIDTH / 16;
   localparam int WD_BITS = $clog2(NWORDS);

   logic [31:0] w_addrExt;
   logic [31:0] w_chanSel;
   logic [31:0] w_wordSel;
   logic        w_busWr;

   // Address is {channel, word}; the word field may be zero bits wide
   assign w_addrExt = 32'(addr);
   assign w_chanSel = w_addrExt >> WD_BITS;
   assign w_wordSel = w_addrExt & ((32'd1 << WD_BITS) - 32'd1);
   assign w_busWr   = write & ~ena;

   for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
      logic [1:0]       r_syncA;
      logic [1:0]       r_syncB;
      logic             w_fltA;
      logic             w_fltB;
      logic [1:0]       w_cur;
      logic [1:0]       r_old;
      logic             w_inc;
      logic             w_dec;
      logic             w_err;
      logic             w_sel;
      logic             w_zeroLoad;
      logic [WIDTH-1:0] r_cnt;
      logic [WIDTH-1:0] w_stepVal;
      logic             r_err;
      logic             r_changed;

      always_ff @(posedge clock or posedge aclr) begin
         if (aclr) begin
            r_syncA <= '0;
            r_syncB <= '0;
         end else if (sclr) begin
            r_syncA <= '0;
            r_syncB <= '0;
         end else begin
            r_syncA <= {r_syncA[0], A[n]};
            r_syncB <= {r_syncB[0], B[n]};
         end
      end

      q_rotary_enc_mc_filter #(.FLT_LEN(FLT_LEN)) u_fltA (
         .clock(clock), .aclr(aclr), .sclr(sclr), .i_d(r_syncA[1]), .o_q(w_fltA));
      q_rotary_enc_mc_filter #(.FLT_LEN(FLT_LEN)) u_fltB (
         .clock(clock), .aclr(aclr), .sclr(sclr), .i_d(r_syncB[1]), .o_q(w_fltB));

      assign w_cur = dir[n] ? {w_fltA, w_fltB} : {w_fltB, w_fltA};
      assign w_sel = w_busWr && (w_chanSel == 32'(n));

      // Grey sequence 00 -> 01 -> 11 -> 10 -> 00 counts up; both bits moving is illegal
      always_comb begin
         w_inc = 1'b0;
         w_dec = 1'b0;
         w_err = 1'b0;
         case ({r_old, w_cur})
            4'b0001, 4'b0111, 4'b1110, 4'b1000: w_inc = 1'b1;
            4'b0100, 4'b1101, 4'b1011, 4'b0010: w_dec = 1'b1;
            4'b0011, 4'b1100, 4'b0110, 4'b1001: w_err = 1'b1;
            default: ;
         endcase
      end

      always_comb begin
         w_stepVal = r_cnt;
         if (w_inc) begin
            w_stepVal = r_cnt + WIDTH'(1);
         end else if (w_dec) begin
            w_stepVal = r_cnt - WIDTH'(1);
         end
      end

`ifdef Q_ROTARY_ENC_MC_INDEX_EN
      logic [1:0]       r_syncZ;
      logic             w_fltZ;
      logic             r_zOld;
      logic             w_zRise;
      logic [WIDTH-1:0] r_idxPos;
      logic             r_idxValid;

      q_rotary_enc_mc_filter #(.FLT_LEN(FLT_LEN)) u_fltZ (
         .clock(clock), .aclr(aclr), .sclr(sclr), .i_d(r_syncZ[1]), .o_q(w_fltZ));

      assign w_zRise    = w_fltZ & ~r_zOld;
      assign w_zeroLoad = ena & w_zRise & idx_zero[n];

      // Capture takes the post-step value, and wins over an acknowledge in the same cycle
      always_ff @(posedge clock or posedge aclr) begin
         if (aclr) begin
            r_syncZ    <= '0;
            r_zOld     <= 1'b0;
            r_idxPos   <= '0;
            r_idxValid <= 1'b0;
         end else if (sclr) begin
            r_syncZ    <= '0;
            r_zOld     <= 1'b0;
            r_idxPos   <= '0;
            r_idxValid <= 1'b0;
         end else begin
            r_syncZ <= {r_syncZ[0], Z[n]};
            r_zOld  <= w_fltZ;
            if (ena & w_zRise) begin
               r_idxPos   <= w_stepVal;
               r_idxValid <= 1'b1;
            end else if (idx_ack[n]) begin
               r_idxValid <= 1'b0;
            end
         end
      end

      assign idx_pos[n*WIDTH +: WIDTH] = r_idxPos;
      assign idx_valid[n]              = r_idxValid;
`else
      assign w_zeroLoad = 1'b0;
`endif

      // Decode state tracks the inputs even while disabled so re-enabling never fakes a step
      always_ff @(posedge clock or posedge aclr) begin
         if (aclr) begin
            r_old     <= '0;
            r_cnt     <= '0;
            r_err     <= 1'b0;
            r_changed <= 1'b0;
         end else if (sclr) begin
            r_old     <= '0;
            r_cnt     <= '0;
            r_err     <= 1'b0;
            r_changed <= 1'b0;
         end else begin
            r_old     <= w_cur;
            r_changed <= ena & (w_inc | w_dec);
            if (ena) begin
               r_cnt <= w_zeroLoad ? '0 : w_stepVal;
               if (w_err) begin
                  r_err <= 1'b1;
               end
            end else if (w_sel) begin
               r_err <= 1'b0;
               for (int w = 0; w < NWORDS; w++) begin
                  if (w_wordSel == 32'(w)) begin
                     if (be[0]) begin
                        r_cnt[w*16 +: 8] <= data[7:0];
                     end
                     if (be[1]) begin
                        r_cnt[w*16+8 +: 8] <= data[15:8];
                     end
                  end
               end
            end
         end
      end

      assign counter[n*WIDTH +: WIDTH] = r_cnt;
      assign error[n]                  = r_err;
      assign enc_changed[n]            = r_changed;
   end
endmodule

// File: doc/q_rotary_enc_mc.md
Name: q_rotary_enc_mc

Overview:
- Multi-channel quadrature encoder counter; successor to the single-channel 32-bit counter.
- Per channel: 2-FF input synchronisers, a programmable glitch filter on A/B, Grey-step decode, a signed up/down counter of parametrised width, and a sticky error flag.
- The CPU bus can preload the counter 16 bits at a time.
- Sits between the optocoupler inputs and the motion controller position registers, one instance per axis group.

Parameters:
- CHANNELS, 2, number of independent encoder channels (1..8).
- WIDTH, 32, counter width in bits; must be a multiple of 16, range 16..64.
- FLT_LEN, 4, number of consecutive identical samples required before a filtered input changes (1..255).

Ports:
- clock  in  1  system clock
- aclr  in  1  asynchronous active-high reset
- sclr  in  1  synchronous clear of all counters, error flags and filter state
- ena  in  1  count enable, global; when 0 the bus may write
- dir  in  CHANNELS  per-channel count direction; 0 = direct ({B,A}), 1 = reverse ({A,B})
- A  in  CHANNELS  raw encoder phase A, asynchronous
- B  in  CHANNELS  raw encoder phase B, asynchronous
- counter  out  CHANNELS*WIDTH  signed positions; channel n occupies bits [n*WIDTH +: WIDTH]
- error  out  CHANNELS  sticky per-channel illegal-transition flag
- enc_changed  out  CHANNELS  one-cycle pulse per valid count step
- addr  in  $clog2(CHANNELS)+$clog2(WIDTH/16)  {channel, word}; word 0 = bits [15:0]
- be  in  2  byte enables
- write  in  1  bus write strobe
- data  in  16  write data

Behaviour:
- Reset: aclr clears all synchronisers, filters, counters, error and enc_changed to 0. sclr has the same effect synchronously and has priority over everything else.
- Synchroniser: 2 FFs per raw input.
- Filter: the filtered bit takes the synchronised value on the edge at which that value has been sampled FLT_LEN consecutive cycles. A shorter pulse is discarded and the run-length counter restarts on every disagreement.
- Latency: clean A or B edge → counter and enc_changed update FLT_LEN+3 clock edges later.
- Decode: cur = filtered code selected by dir; old = cur registered.
  - cur == old → no action.
  - One-step Grey increment (00→01→11→10→00) → inc.
  - Reverse step → dec.
  - Both bits changed → err.
- Counter, when ena=1: inc adds 1, dec subtracts 1.
  - Two's-complement wrap: max → min and min → max, with no error.
  - enc_changed = ena & (inc|dec), combinational from registered state; one pulse per step.
- Error: set when ena & err. Cleared by sclr. Also cleared by any bus write to that channel while ena=0. A set and a clear in the same cycle is impossible because they are gated by opposite ena values.
- Bus write: accepted only when ena=0; ignored otherwise, with no side effect.
  - Selected word: be[0] loads byte 0, be[1] loads byte 1.
  - Other words are unchanged; writes may be partial.
  - addr channel index ≥ CHANNELS → write ignored.
- While ena=0, decode state (old) keeps tracking the inputs, so no false step occurs on re-enable.
- Channels are fully independent; simultaneous steps on all channels are all counted.
- Filter sub-block is a separate module reused for Z if enabled.

Optional Feature:
- Macro Q_ROTARY_ENC_MC_INDEX_EN.
- When defined:
  - Adds ports: Z in CHANNELS; idx_pos out CHANNELS*WIDTH; idx_valid out CHANNELS; idx_ack in CHANNELS; idx_zero in CHANNELS.
  - Z passes through the same sync and filter as A/B.
  - A filtered Z rising edge while ena=1 latches the counter value into idx_pos and sets idx_valid. The latched value is the value after any step in that same cycle.
  - If idx_zero[n]=1, the counter is also loaded with 0 on that edge. In that case idx_pos holds the pre-zero post-step value.
  - idx_ack pulse clears idx_valid; a capture in the same cycle wins.
  - aclr/sclr clear idx_pos and idx_valid.
- When undefined: the ports are absent and there is no index logic.

Test Plan:
- aclr pulse mid-count → counter, error and enc_changed all 0 asynchronously; a count resumes correctly after release.
- Channel 0, dir=0, FLT_LEN=4, 10 clean forward Grey steps spaced 10 cycles apart → counter0 = 10, with 10 enc_changed pulses each FLT_LEN+3 edges after the input edge; channel 1 stays 0.
- 3-cycle glitch on A → no count, no error. Jump from 00 to 11 held 10 cycles → error0 = 1, counter unchanged.
- ena=0, write addr={1,0} be=11 data=0xFFFF, then addr={1,1} data=0x7FFF → counter1 = 0x7FFFFFFF. Then ena=1 with one forward step → 0x80000000, and error1 was cleared by the write.
- ena=1 with a write to channel 0 → ignored; counter and error unchanged.
- With INDEX_EN: counter0 = 25, Z rise with idx_zero=1 → idx_pos0 = 25, idx_valid0 = 1, counter0 = 0; idx_ack → idx_valid0 = 0.
